gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Sequencing controller for the 3-bit Gray counter: runs it for an exact number of enabled cycles per command.
- Clears the counter before each run, supports abort, and reports the final Gray value, the step count and a wrap flag.
- Sits between a command source (Start/Steps) and the counter's Reset/En/Output/Overflow pins; the counter stays a separate instance.
- Counter contract: synchronous Reset clears Output to 0 and Overflow to 0. Each clock with En=1 advances Output one Gray step. The step from 3'b100 to 3'b000 sets Overflow, which stays 1 until Reset.

Parameters:
- STEP_W, 8, width of Steps and StepsDone (max run length 2^STEP_W-1).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Steps  in  STEP_W  number of counter enables requested; latched on accepted Start.
- Abort  in  1  terminate the current run; ignored when not Busy.
- CntEn  out  1  drives the counter's En.
- CntReset  out  1  drives the counter's Reset.
- CntValue  in  3  the counter's Output.
- CntOverflow  in  1  the counter's Overflow.
- Busy  out  1  high from the cycle after an accepted Start through the DONE cycle.
- Done  out  1  one-cycle completion pulse.
- Aborted  out  1  last run ended by Abort; held until the next accepted Start.
- Wrapped  out  1  CntOverflow sampled at completion; held until the next accepted Start.
- FinalValue  out  3  CntValue sampled at completion; held until the next accepted Start.
- StepsDone  out  STEP_W  number of cycles CntEn was high in the last run; held until the next accepted Start.

Behaviour:
- Reset: state IDLE. All registered outputs 0 (Busy, Done, Aborted, Wrapped, FinalValue, StepsDone); internal remaining count 0.
- CntReset = Reset OR (state==CLEAR), so the counter is reset together with the controller.
- CntEn = (state==RUN) AND NOT Abort. Combinational; no other source.
- State IDLE:
  - Start with Steps!=0 -> CLEAR; latch remaining=Steps; clear Aborted, Wrapped, FinalValue, StepsDone.
  - Start with Steps==0 -> DONE directly; no CntReset, no CntEn; Done reports FinalValue=0, StepsDone=0.
- State CLEAR (1 cycle): CntReset=1.
  - Abort -> DONE with Aborted=1.
  - Otherwise -> RUN.
- State RUN: CntEn=1 each cycle; remaining decrements; StepsDone increments.
  - When remaining==1 and no Abort -> DONE.
  - Abort (higher priority than the final step) -> DONE with Aborted=1; CntEn is 0 that cycle and no increment occurs.
- State DONE (1 cycle): Done=1; FinalValue<=CntValue; Wrapped<=CntOverflow; -> IDLE.
- Latency, Start accepted at edge t with Steps=N>0:
  - CLEAR cycle t+1.
  - CntEn high in cycles t+2 .. t+1+N.
  - Done in cycle t+2+N.
  - Busy high t+1 .. t+2+N.
- Result: FinalValue = gray(N mod 8) = (N mod 8) XOR ((N mod 8)>>1). Wrapped = (N>=8).
- Start while Busy: ignored, no queuing. Start in the DONE cycle is also ignored; the next Start is accepted earliest in the following IDLE cycle.
- Steps is sampled only on accepted Start; later changes have no effect on the run.
- Reset mid-operation: immediate return to IDLE next edge; no Done pulse; counter is cleared through CntReset.
- CntValue and CntOverflow are used only in DONE; their values in other states are don't-care.

Decomposition:
- Package gray_seq_pkg holds:
  - state enum {IDLE, CLEAR, RUN, DONE} (2-bit encoding);
  - constant GRAY_W=3;
  - a bin2gray function, shared by the RTL assertion and the bench scoreboard.
- No sub-module: a single FSM plus a down-counter fits in one module. The Gray counter is instantiated beside the controller in the bench and top, not inside it.

Test Plan:
- Reset, then Start with Steps=5 at t -> CntReset high at t+1; CntEn high t+2..t+6; Done at t+7; FinalValue=3'b111, Wrapped=0, StepsDone=5, Aborted=0.
- Steps=8 -> CntEn high 8 cycles; FinalValue=3'b000, Wrapped=1. Then Steps=2 -> counter cleared first; FinalValue=3'b011, Wrapped=0.
- Steps=0 -> Done one cycle after Start; CntReset and CntEn never asserted; FinalValue=0, StepsDone=0.
- Steps=10, Abort during the 4th RUN cycle -> CntEn seen high exactly 3 cycles; Done next cycle; Aborted=1, StepsDone=3, FinalValue=3'b010.
- Start pulsed while Busy (Steps=3 run in progress, second Start with Steps=7) -> ignored; single Done; StepsDone=3.
- Reset asserted mid-RUN -> next cycle Busy=0, all outputs 0, no Done pulse, counter Output=0; a fresh Start with Steps=1 then gives FinalValue=3'b001.

Source files
------------

// File: rtl/gray_seq_pkg.sv
// Purpose : shared types and helpers for the Gray counter sequencing controller.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: controller state enum, Gray width, binary-to-Gray helper.
package gray_seq_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Purpose : bundles the command, counter-pin and result signals of gray_seq_ctrl.
// Latency : n/a (wiring only).
// Backpressure: none; Start is a strobe that is simply ignored while the controller is busy.
// Signals : start/steps/abort (command), cnt_en/cnt_reset/cnt_value/cnt_overflow (counter pins),
//           busy/done/aborted/wrapped/final_value/steps_done (status and results).
// master = command source plus counter side, slave = the controller.
interface gray_seq_ctrl_if
  import gray_seq_pkg::*;
#(
  parameter int STEP_W = 8
);

  logic              start;
  logic [STEP_W-1:0] steps;
  logic              abort;
  logic              cnt_en;
  logic              cnt_reset;
  logic [GRAY_W-1:0] cnt_value;
  logic              cnt_overflow;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              wrapped;
  logic [GRAY_W-1:0] final_value;
  logic [STEP_W-1:0] steps_done;

  modport master (
    output start, steps, abort, cnt_value, cnt_overflow,
    input  cnt_en, cnt_reset, busy, done, aborted, wrapped, final_value, steps_done
  );

  modport slave (
    input  start, steps, abort, cnt_value, cnt_overflow,
    output cnt_en, cnt_reset, busy, done, aborted, wrapped, final_value, steps_done
  );

endinterface

// File: rtl/gray_seq_ctrl.sv
// Purpose : runs an external 3-bit Gray counter for exactly Steps enabled cycles per Start.
// Latency : Start at edge t with Steps=N>0 -> CLEAR t+1, En t+2..t+1+N, Done t+2+N (N=0: Done t+1).
// Backpressure: Start is accepted only in IDLE; Start while busy (including DONE) is dropped.
// Ports   : i_clk, i_reset (sync, active-high); bus (slave modport) carries the command,
//           counter pins and the held result registers.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  gray_seq_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_next_state;
  logic [STEP_W-1:0] r_remaining;
  logic [STEP_W-1:0] r_steps_done;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              r_wrapped;
  logic [GRAY_W-1:0] r_final_value;
  // A zero-length run never clears the counter, so its pins still hold the
  // previous run's result; this flag stops DONE from sampling them.
  logic              r_skip_sample;
  logic              w_cnt_en;
  logic              w_cnt_reset;

  always_comb begin
    w_next_state = r_state;
    w_cnt_en     = 1'b0;
    w_cnt_reset  = i_reset;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = (bus.steps != '0) ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        w_cnt_reset  = 1'b1;
        w_next_state = bus.abort ? DONE : RUN;
      end
      RUN: begin
        // Abort wins over the final step: no enable is issued in the abort cycle.
        w_cnt_en = !bus.abort;
        if (bus.abort || (r_remaining == STEP_W'(1))) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_steps_done  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_wrapped     <= 1'b0;
      r_final_value <= '0;
      r_skip_sample <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Busy/Done are registered off the next state so they line up with the state itself.
      r_busy  <= (w_next_state != IDLE);
      r_done  <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_remaining   <= bus.steps;
            r_steps_done  <= '0;
            r_aborted     <= 1'b0;
            r_wrapped     <= 1'b0;
            r_final_value <= '0;
            r_skip_sample <= (bus.steps == '0);
          end
        end
        CLEAR: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_aborted <= 1'b1;
          end else begin
            r_remaining  <= r_remaining - STEP_W'(1);
            r_steps_done <= r_steps_done + STEP_W'(1);
          end
        end
        DONE: begin
          if (!r_skip_sample) begin
            r_final_value <= bus.cnt_value;
            r_wrapped     <= bus.cnt_overflow;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The counter was cleared then enabled exactly r_steps_done times, so its
  // output in DONE must be the Gray code of that count modulo 8.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (r_state == DONE) && !r_skip_sample) begin
      assert (bus.cnt_value == bin2gray(GRAY_W'(r_steps_done)));
    end
  end

  assign bus.cnt_en      = w_cnt_en;
  assign bus.cnt_reset   = w_cnt_reset;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;
  assign bus.wrapped     = r_wrapped;
  assign bus.final_value = r_final_value;
  assign bus.steps_done  = r_steps_done;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Purpose : self-checking bench for gray_seq_ctrl with a behavioural 3-bit Gray counter beside it.
// Latency : checks Done timing against the Start acceptance edge for every run.
// Backpressure: exercises Start while busy and Start in the DONE cycle (both dropped).
module tb_gray_seq_ctrl;
  import gray_seq_pkg::*;

  localparam int STEP_W = 8;

  typedef struct {
    int steps;
    int abort_at;  // -1 none, 0 during CLEAR, k during k-th RUN cycle
    int en;        // expected enabled cycles (= StepsDone)
    int ab;
    int clr;       // expected CntReset cycles outside system reset
    int lat;       // Done cycle offset from the accepting edge
  } vec_t;

  typedef struct {
    logic [2:0] fin;
    logic       wrap;
    int         sd;
    logic       ab;
    int         en;
    int         clr;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.STEP_W(STEP_W)) bus ();

  gray_seq_ctrl #(.STEP_W(STEP_W)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // Behavioural stand-in for the separate Gray counter instance.
  logic [2:0] g_val;
  logic       g_ovf;

  function automatic logic [2:0] gray_next(input logic [2:0] g);
    case (g)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b010;
      3'b010:  return 3'b110;
      3'b110:  return 3'b111;
      3'b111:  return 3'b101;
      3'b101:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (bus.cnt_reset) begin
      g_val <= 3'b000;
      g_ovf <= 1'b0;
    end else if (bus.cnt_en) begin
      g_val <= gray_next(g_val);
      if (g_val == 3'b100) g_ovf <= 1'b1;
    end
  end

  assign bus.cnt_value    = g_val;
  assign bus.cnt_overflow = g_ovf;

  int   n_chk = 0;
  int   n_err = 0;
  int   ncyc  = 0;
  int   en_cnt = 0;
  int   clr_cnt = 0;
  bit   pend = 1'b0;
  exp_t sb_q[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic push_exp(input int en, input int ab, input int clr, input int dc);
    exp_t e;
    e.fin      = bin2gray(GRAY_W'(en));
    e.wrap     = (en >= 8);
    e.sd       = en;
    e.ab       = ab[0];
    e.en       = en;
    e.clr      = clr;
    e.done_cyc = dc;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, checks the Done cycle, then the held results one cycle later.
  always @(negedge clk) begin : mon
    exp_t e;
    ncyc++;
    if (rst) begin
      en_cnt  = 0;
      clr_cnt = 0;
      pend    = 1'b0;
    end else begin
      if (bus.cnt_en)    en_cnt++;
      if (bus.cnt_reset) clr_cnt++;
      if (pend) begin
        e    = sb_q.pop_front();
        pend = 1'b0;
        chk("final_value", 32'(bus.final_value), 32'(e.fin));
        chk("wrapped",     32'(bus.wrapped),     32'(e.wrap));
        chk("steps_done",  32'(bus.steps_done),  e.sd);
        chk("aborted",     32'(bus.aborted),     32'(e.ab));
        chk("busy_after_done", 32'(bus.busy), 0);
        en_cnt  = 0;
        clr_cnt = 0;
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 want 0 (cycle %0d)", ncyc);
        end else begin
          e = sb_q[0];
          chk("done_cycle",       ncyc,    e.done_cyc);
          chk("cnt_en_cycles",    en_cnt,  e.en);
          chk("cnt_reset_cycles", clr_cnt, e.clr);
          chk("busy_in_done",     32'(bus.busy), 1);
          pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    if (bus.busy) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_idle_timeout: got busy=1 want 0");
    end
  endtask

  // Drives Start at posedge+1; returns the monitor cycle number of the accepting edge.
  task automatic issue_start(input int steps, output int acc);
    bus.start = 1'b1;
    bus.steps = STEP_W'(steps);
    @(posedge clk); #1;
    acc       = ncyc;
    bus.start = 1'b0;
    bus.steps = STEP_W'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    wait_idle();
    issue_start(v.steps, acc);
    push_exp(v.en, v.ab, v.clr, acc + v.lat);
    chk("busy_after_start", 32'(bus.busy), 1);
    if (v.abort_at >= 0) begin
      repeat (v.abort_at) @(posedge clk);
      if (v.abort_at > 0) #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int acc;
    int i;
    vec_t last;

    //          steps abort en ab clr lat
    vecs[0]  = '{5,   -1,   5,  0, 1,  7};
    vecs[1]  = '{8,   -1,   8,  0, 1,  10};
    vecs[2]  = '{2,   -1,   2,  0, 1,  4};
    vecs[3]  = '{0,   -1,   0,  0, 0,  1};
    vecs[4]  = '{10,   4,   3,  1, 1,  6};
    vecs[5]  = '{1,   -1,   1,  0, 1,  3};
    vecs[6]  = '{7,   -1,   7,  0, 1,  9};
    vecs[7]  = '{9,   -1,   9,  0, 1,  11};
    vecs[8]  = '{4,    0,   0,  1, 1,  2};
    vecs[9]  = '{6,    1,   0,  1, 1,  3};
    vecs[10] = '{3,    3,   2,  1, 1,  5};
    vecs[11] = '{255, -1, 255,  0, 1,  257};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.steps = '0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_reset_during_reset", 32'(bus.cnt_reset), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy",        32'(bus.busy),        0);
    chk("rst_done",        32'(bus.done),        0);
    chk("rst_aborted",     32'(bus.aborted),     0);
    chk("rst_wrapped",     32'(bus.wrapped),     0);
    chk("rst_final_value", 32'(bus.final_value), 0);
    chk("rst_steps_done",  32'(bus.steps_done),  0);
    chk("rst_cnt_en",      32'(bus.cnt_en),      0);
    chk("rst_cnt_reset",   32'(bus.cnt_reset),   0);

    for (int k = 0; k < 12; k++) run_vec(vecs[k]);

    // Start while busy: second command must be dropped.
    issue_start(3, acc);
    push_exp(3, 0, 1, acc + 5);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.steps = STEP_W'(7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // Start in the DONE cycle: dropped, controller returns to IDLE.
    issue_start(1, acc);
    push_exp(1, 0, 1, acc + 3);
    for (i = 0; i < 10 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    chk("reached_done", 32'(bus.done), 1);
    bus.start = 1'b1;
    bus.steps = STEP_W'(2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_in_done_ignored", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("still_idle", 32'(bus.busy), 0);

    // Reset mid-RUN: no Done, everything cleared, counter cleared.
    issue_start(6, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",        32'(bus.busy),        0);
    chk("midrst_done",        32'(bus.done),        0);
    chk("midrst_steps_done",  32'(bus.steps_done),  0);
    chk("midrst_final_value", 32'(bus.final_value), 0);
    chk("midrst_aborted",     32'(bus.aborted),     0);
    chk("midrst_counter",     32'(g_val),           0);
    repeat (10) @(posedge clk);
    #1;
    last = '{1, -1, 1, 0, 1, 3};
    run_vec(last);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
